// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte requesters. Round-robin arbitration with
// packet locking: once a requester sends a byte without last, it keeps the
// transmitter until its last byte completes or a byte times out.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200_000,
  localparam int unsigned IdW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_start,
  output logic [DATA_BITS-1:0]           tx_data,
  input  logic                           tx_busy,
  input  logic                           tx_done,
  output logic [IdW-1:0]                 grant_id,
  output logic                           active,
  output logic                           timeout_err
);

  localparam logic [31:0]    TimeoutLast = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [IdW-1:0] LastId      = IdW'(NUM_REQ - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWaitDone} state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 last_q, last_d;
  logic [IdW-1:0]       grant_id_q, grant_id_d;
  logic [IdW-1:0]       rr_ptr_q, rr_ptr_d;
  logic                 lock_q, lock_d;
  logic [31:0]          wait_cnt_q, wait_cnt_d;
  logic                 timeout_err_q, timeout_err_d;

  logic                 rr_found;
  logic [IdW-1:0]       rr_idx;
  logic [31:0]          cand;
  logic                 win_valid;
  logic [IdW-1:0]       win_idx;
  logic [DATA_BITS-1:0] win_data;
  logic                 win_last;
  logic                 grant;
  logic [IdW-1:0]       next_ptr;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = 32'(rr_ptr_q) + off;
      // rr_ptr is always below NUM_REQ, so one subtraction is enough to wrap.
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!rr_found && req_valid[cand[IdW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[IdW-1:0];
      end
    end
  end

  // Winner selection: a held lock overrides round robin, even when the
  // locked requester is momentarily not valid.
  always_comb begin
    win_valid = lock_q ? req_valid[grant_id_q] : rr_found;
    win_idx   = lock_q ? grant_id_q : rr_idx;
    win_data  = '0;
    win_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IdW'(i)) begin
        win_data = req_data[i*DATA_BITS +: DATA_BITS];
        win_last = req_last[i];
      end
    end
  end

  assign grant    = !rst && (state_q == StIdle) && !tx_busy && win_valid;
  assign next_ptr = (grant_id_q == LastId) ? '0 : grant_id_q + IdW'(1);

  // Accept strobe for the winner only.
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant && (win_idx == IdW'(i));
    end
  end

  // Next-state logic for the FSM and its datapath registers.
  always_comb begin
    state_d       = state_q;
    tx_data_d     = tx_data_q;
    last_d        = last_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    lock_d        = lock_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d    = StStart;
          tx_data_d  = win_data;
          last_d     = win_last;
          grant_id_d = win_idx;
        end
      end
      StStart: begin
        state_d    = StWaitDone;
        wait_cnt_d = '0;
      end
      StWaitDone: begin
        // tx_done has priority over a coincident timeout.
        if (tx_done) begin
          state_d = StIdle;
          if (last_q) begin
            lock_d   = 1'b0;
            rr_ptr_d = next_ptr;
          end else begin
            lock_d = 1'b1;
          end
        end else if (wait_cnt_q == TimeoutLast) begin
          state_d       = StIdle;
          timeout_err_d = 1'b1;
          lock_d        = 1'b0;
          rr_ptr_d      = next_ptr;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      tx_data_q     <= '0;
      last_q        <= 1'b0;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
      lock_q        <= 1'b0;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_data_q     <= tx_data_d;
      last_q        <= last_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      lock_q        <= lock_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign tx_start    = (state_q == StStart);
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign active      = (state_q != StIdle) || lock_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a transaction-level model predicts
// the byte order; monitor, requester drivers and a uart_tx responder run
// concurrently and are checked through a scoreboard queue.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int T  = 50;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*8-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_busy;
  logic            tx_done;
  logic [1:0]      grant_id;
  logic            active;
  logic            timeout_err;

  uart_tx_arbiter #(
    .NUM_REQ       (NR),
    .DATA_BITS     (8),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .grant_id   (grant_id),
    .active     (active),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    int unsigned id;
    logic [7:0]  data;
  } exp_t;

  int   checks, errors;
  exp_t exp_q[$];
  int   dly_q[$];
  exp_t pexp;
  bit   pend, done, uart_busy, aborted;
  int   te_seen, te_exp;
  int   model_rr;

  // Per-requester byte lists for the current phase.
  logic [7:0] pk_data[NR][8];
  bit         pk_last[NR][8];
  int         pk_gap [NR][8];
  int         pk_cnt [NR];
  int         hd     [NR];
  int         gapc   [NR];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_pk();
    for (int i = 0; i < NR; i++) begin
      pk_cnt[i] = 0;
      hd[i]     = 0;
      gapc[i]   = 0;
    end
  endtask

  task automatic add_byte(input int r, input logic [7:0] d, input bit last);
    pk_data[r][pk_cnt[r]] = d;
    pk_last[r][pk_cnt[r]] = last;
    pk_gap[r][pk_cnt[r]]  = 0;
    pk_cnt[r]++;
  endtask

  task automatic add_pkt(input int r, input int len);
    for (int b = 0; b < len; b++) add_byte(r, 8'($urandom_range(0, 255)), b == len - 1);
  endtask

  function automatic int rand_delay();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 0;      // never answer: timeout
    if (r == 1) return T;      // done on the last allowed cycle
    if (r == 2) return 1;
    return int'($urandom_range(1, 12));
  endfunction

  // Transaction-level arbitration model: walks the pending bytes, deciding
  // the global order from lock/round-robin rules and the fate of each byte.
  task automatic model_gen(input int fd);
    int ptr[NR];
    bit prev_ok[NR];
    int lock, w, c, d;
    bit more;
    exp_t e;
    te_exp = 0;
    lock   = -1;
    more   = 1'b1;
    for (int i = 0; i < NR; i++) begin
      ptr[i]     = 0;
      prev_ok[i] = 1'b0;
    end
    while (more) begin
      w = -1;
      if (lock >= 0) begin
        if (ptr[lock] < pk_cnt[lock]) w = lock;
      end else begin
        for (int off = 0; off < NR; off++) begin
          c = (model_rr + off) % NR;
          if (w < 0 && ptr[c] < pk_cnt[c]) w = c;
        end
      end
      if (w < 0) begin
        more = 1'b0;
      end else begin
        // Mid-packet bytes may arrive late; the lock must hold meanwhile.
        pk_gap[w][ptr[w]] = prev_ok[w] ? int'($urandom_range(0, 12)) : 0;
        d      = (fd >= 0) ? fd : rand_delay();
        e.id   = w;
        e.data = pk_data[w][ptr[w]];
        exp_q.push_back(e);
        dly_q.push_back(d);
        if (d == 0) te_exp++;
        if (d == 0 || pk_last[w][ptr[w]]) begin
          lock     = -1;
          model_rr = (w + 1) % NR;
        end else begin
          lock = w;
        end
        prev_ok[w] = (d != 0) && !pk_last[w][ptr[w]];
        ptr[w]++;
      end
    end
  endtask

  function automatic bit drv_empty();
    for (int i = 0; i < NR; i++) if (hd[i] < pk_cnt[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_loop(input bit busy_rand);
    logic [NR-1:0] acc;
    while (!done) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (acc[i] && hd[i] < pk_cnt[i]) begin
          hd[i]++;
          gapc[i] = (hd[i] < pk_cnt[i]) ? pk_gap[i][hd[i]] : 0;
        end else if (gapc[i] > 0) begin
          gapc[i]--;
        end
        if (hd[i] < pk_cnt[i]) begin
          req_data[i*8 +: 8] = pk_data[i][hd[i]];
          req_last[i]        = pk_last[i][hd[i]];
        end
        req_valid[i] = (hd[i] < pk_cnt[i]) && (gapc[i] == 0);
      end
      tx_busy = busy_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    req_valid = '0;
    tx_busy   = 1'b0;
  endtask

  task automatic uart_loop();
    int d;
    while (!done) begin
      @(negedge clk);
      if (tx_start) begin
        uart_busy = 1'b1;
        d = (dly_q.size() == 0) ? 1 : dly_q.pop_front();
        if (d > 0) begin
          repeat (d) @(posedge clk);
          #1 tx_done = 1'b1;
          @(posedge clk);
          #1 tx_done = 1'b0;
        end else begin
          for (int k = 1; k <= T + 1; k++) begin
            @(negedge clk);
            if (k >= T) check("timeout_pulse", {31'b0, timeout_err}, (k == T + 1) ? 1 : 0);
          end
        end
        uart_busy = 1'b0;
      end
    end
  endtask

  task automatic mon_loop(input bit first_chk);
    bit   first;
    exp_t e;
    first = first_chk;
    while (!done) begin
      @(negedge clk);
      if (first) begin
        check("first_cycle_grant", 32'(req_ready), 32'b0100);
        first = 1'b0;
      end
      if (pend) begin
        check("start_data", 32'({tx_start, grant_id, tx_data}),
              32'({1'b1, pexp.id[1:0], pexp.data}));
        pend = 1'b0;
      end else if (tx_start) begin
        check("unexpected_start", 32'(tx_start), 0);
      end
      if (req_ready != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 32'(req_ready), 0);
        end else begin
          e = exp_q.pop_front();
          check("grant", 32'({tx_done, tx_busy, req_ready}), 32'(1) << e.id);
          pexp = e;
          pend = 1'b1;
        end
      end
      if (timeout_err) te_seen++;
    end
  endtask

  task automatic watch_loop();
    int cyc;
    cyc = 0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() == 0 && dly_q.size() == 0 && !uart_busy && !pend && drv_empty()) begin
        done = 1'b1;
      end else if (cyc > 4000) begin
        checks++;
        errors++;
        $display("FAIL phase_stall: %0d bytes still expected after %0d cycles", exp_q.size(), cyc);
        aborted = 1'b1;
        done    = 1'b1;
      end
    end
  endtask

  task automatic run_phase(input int fd, input bit busy_rand, input bit first_chk);
    if (aborted) return;
    model_gen(fd);
    for (int i = 0; i < NR; i++) begin
      hd[i]   = 0;
      gapc[i] = 0;
    end
    done      = 1'b0;
    pend      = 1'b0;
    uart_busy = 1'b0;
    te_seen   = 0;
    fork
      drive_loop(busy_rand);
      uart_loop();
      mon_loop(first_chk);
      watch_loop();
    join
    check("timeout_count", te_seen, te_exp);
    exp_q.delete();
    dly_q.delete();
    clear_pk();
  endtask

  bit seen;

  initial begin
    checks    = 0;
    errors    = 0;
    aborted   = 1'b0;
    model_rr  = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    clear_pk();

    // Single byte 0x41 from requester 2, presented while still in reset.
    add_byte(2, 8'h41, 1'b1);
    req_valid          = 4'b0100;
    req_data[2*8 +: 8] = 8'h41;
    req_last           = 4'b0100;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_active", 32'(active), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_phase(10, 1'b0, 1'b1);

    // Requester 3 alone, moving the pointer back to 0.
    add_byte(3, 8'h33, 1'b1);
    run_phase(3, 1'b0, 1'b0);

    // All valid, single-byte packets: order 0,1,2,3,0.
    add_byte(0, 8'h10, 1'b1);
    add_byte(0, 8'h11, 1'b1);
    add_byte(1, 8'h21, 1'b1);
    add_byte(2, 8'h22, 1'b1);
    add_byte(3, 8'h23, 1'b1);
    run_phase(3, 1'b0, 1'b0);

    // Packet lock: three bytes from 1 before requester 0 gets in.
    add_pkt(1, 3);
    add_byte(0, 8'hA0, 1'b1);
    run_phase(5, 1'b0, 1'b0);

    // Timeouts: tx_done never arrives.
    add_pkt(1, 2);
    add_byte(2, 8'hC2, 1'b1);
    run_phase(0, 1'b0, 1'b0);

    // Randomized traffic, delays and busy.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < NR; i++) begin
        int npk;
        npk = int'($urandom_range(0, 2));
        for (int p = 0; p < npk; p++) add_pkt(i, int'($urandom_range(1, 3)));
      end
      run_phase(-1, 1'b1, 1'b0);
    end

    // tx_busy blocks grants in IDLE.
    @(posedge clk);
    #1;
    tx_busy         = 1'b1;
    req_valid       = 4'b0001;
    req_data        = '0;
    req_data[7:0]   = 8'h5A;
    req_last        = '0;
    seen            = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (req_ready != '0) seen = 1'b1;
    end
    check("busy_blocks", 32'(seen), 0);
    @(posedge clk);
    #1 tx_busy = 1'b0;
    @(negedge clk);
    check("busy_release_grant", 32'(req_ready), 1);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("busy_start", 32'({tx_start, grant_id, tx_data}), 32'({1'b1, 2'd0, 8'h5A}));
    repeat (5) @(negedge clk);
    check("wait_active", 32'(active), 1);

    // Reset in the middle of WAIT_DONE.
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_tx_start", 32'(tx_start), 0);
    check("midrst_tx_data", 32'(tx_data), 0);
    check("midrst_grant_id", 32'(grant_id), 0);
    check("midrst_active", 32'(active), 0);
    check("midrst_timeout_err", 32'(timeout_err), 0);
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (timeout_err) seen = 1'b1;
    end
    check("no_timeout_after_rst", 32'(seen), 0);

    // Round-robin pointer restarts at 0 after reset.
    @(posedge clk);
    #1 req_valid = 4'b1010;
    @(negedge clk);
    check("rr_after_rst", 32'(req_ready), 32'b0010);
    @(posedge clk);
    #1 req_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
